// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester, message-granular arbiter in front of a UART transmitter
// Round-robin between requesters at message boundaries, one byte in flight, per-byte watchdog.
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       txd_en,
    output logic [7:0] txd_data,
    input  logic       txd_flag,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err
);

    localparam int              WD_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [7:0]      data_q, data_d;
    logic            last_q, last_d;
    logic            ptr_q, ptr_d;      // 1: req1 was served last
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    logic            pick1;
    logic            own_valid;
    logic [7:0]      own_data;
    logic            own_last;
    logic            wd_expired;

    assign own_valid  = grant_q[1] ? req1_valid : req0_valid;
    assign own_data   = grant_q[1] ? req1_data  : req0_data;
    assign own_last   = grant_q[1] ? req1_last  : req0_last;
    assign wd_expired = (wd_q == WD_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= 2'b00;
            data_q    <= 8'h00;
            last_q    <= 1'b0;
            ptr_q     <= 1'b1;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            last_q    <= last_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        data_d    = data_q;
        last_d    = last_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        timeout_d = 1'b0;
        pick1     = req1_valid && (!req0_valid || !ptr_q);

        case (state_q)
            S_IDLE: begin
                wd_d = '0;
                if (req0_valid || req1_valid) begin
                    // Byte and last flag are latched here so txd_data is a clean register in LOAD.
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    data_d  = pick1 ? req1_data : req0_data;
                    last_d  = pick1 ? req1_last : req0_last;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (txd_flag) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        grant_d = 2'b00;
                        ptr_d   = grant_q[1];
                    end else begin
                        state_d = S_HOLD;
                        wd_d    = '0;
                    end
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                    grant_d   = 2'b00;
                    ptr_d     = grant_q[1];
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_HOLD: begin
                if (own_valid) begin
                    data_d  = own_data;
                    last_d  = own_last;
                    state_d = S_LOAD;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                    grant_d   = 2'b00;
                    ptr_d     = grant_q[1];
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    assign txd_en      = (state_q == S_LOAD);
    assign txd_data    = data_q;
    assign req0_ready  = txd_en & grant_q[0];
    assign req1_ready  = txd_en & grant_q[1];
    assign grant       = grant_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int TO_CYC   = 100;
    localparam int FLAG_DLY = 20;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_last, req0_ready;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic       txd_en, txd_flag, busy, timeout_err;
    logic [7:0] txd_data;
    logic [1:0] grant;

    logic       man_flag, mdl_flag, flag_en, hold0;
    logic [8:0] m0 [64];
    logic [8:0] m1 [64];
    int         tail0, tail1, head0, head1;
    int         n_en, n_r0, n_r1, n_bad, n_to, n_gill;
    logic [9:0] log_q [$];
    int         checks, failures;

    assign txd_flag = man_flag | mdl_flag;

    uart_tx_arbiter #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .txd_en(txd_en), .txd_data(txd_data), .txd_flag(txd_flag),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // requester 0 model
    initial begin
        head0 = 0; req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) head0 = tail0;
            else if (req0_ready) head0++;
            req0_valid = rst_n && (head0 != tail0) && !hold0;
            {req0_last, req0_data} = m0[head0 & 63];
        end
    end

    // requester 1 model
    initial begin
        head1 = 0; req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) head1 = tail1;
            else if (req1_ready) head1++;
            req1_valid = rst_n && (head1 != tail1);
            {req1_last, req1_data} = m1[head1 & 63];
        end
    end

    // UART transmitter model
    initial begin
        mdl_flag = 1'b0;
        forever begin
            @(negedge clk);
            if (txd_en && flag_en) begin
                repeat (FLAG_DLY) @(negedge clk);
                mdl_flag = 1'b1;
                @(negedge clk);
                mdl_flag = 1'b0;
            end
        end
    end

    // event monitor
    initial begin
        n_en = 0; n_r0 = 0; n_r1 = 0; n_bad = 0; n_to = 0; n_gill = 0;
        forever begin
            @(negedge clk);
            if (txd_en) begin
                n_en++;
                log_q.push_back({grant, txd_data});
            end
            if (req0_ready) begin n_r0++; if (grant != 2'b01) n_bad++; end
            if (req1_ready) begin n_r1++; if (grant != 2'b10) n_bad++; end
            if (timeout_err) n_to++;
            if (busy && !(grant == 2'b01 || grant == 2'b10)) n_gill++;
            if (!busy && grant != 2'b00) n_gill++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic push0(input logic [7:0] d, input logic l);
        m0[tail0 & 63] = {l, d};
        tail0++;
    endtask

    task automatic push1(input logic [7:0] d, input logic l);
        m1[tail1 & 63] = {l, d};
        tail1++;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n;
        n = 0;
        while ((head0 != tail0 || head1 != tail1 || busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, n >= limit, 0);
    endtask

    task automatic wait_en(input string tag);
        int n;
        n = 0;
        while (!txd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, txd_en, 1);
    endtask

    task automatic chk_log(input string tag, input int base, input logic [9:0] e [$]);
        check({tag, "_n"}, log_q.size() - base, e.size());
        for (int i = 0; i < e.size(); i++)
            if (base + i < log_q.size())
                check($sformatf("%s_%0d", tag, i), log_q[base + i], e[i]);
    endtask

    task automatic lat_req1(input string tag, input logic [7:0] d);
        @(posedge clk);
        #1 push1(d, 1'b1);
        @(negedge clk);
        check({tag, "_pre"}, txd_en, 0);
        @(negedge clk);
        check({tag, "_en"}, txd_en, 1);
        check({tag, "_grant"}, grant, 2'b10);
        check({tag, "_data"}, txd_data, d);
        check({tag, "_rdy1"}, req1_ready, 1);
        wait_done({tag, "_done"}, 200);
    endtask

    initial begin
        int         base, cyc, b_en, b_r0, b_r1, b_to;
        logic [9:0] e [$];

        checks = 0; failures = 0;
        rst_n = 1'b0; man_flag = 1'b0; flag_en = 1'b1; hold0 = 1'b0;
        tail0 = 0; tail1 = 0;
        foreach (m0[i]) begin m0[i] = '0; m1[i] = '0; end

        repeat (3) @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_txd_en", txd_en, 0);
        check("rst_txd_data", txd_data, 8'h00);
        check("rst_ready", {req1_ready, req0_ready}, 2'b00);
        check("rst_timeout", timeout_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // stray txd_flag in IDLE
        b_en = n_en; b_r0 = n_r0; b_r1 = n_r1; b_to = n_to;
        man_flag = 1'b1;
        @(negedge clk);
        man_flag = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_busy", busy, 0);
        check("stray_pulses", (n_en - b_en) + (n_r0 - b_r0) + (n_r1 - b_r1) + (n_to - b_to), 0);

        // single three-byte message from req0
        base = log_q.size(); b_r0 = n_r0; b_r1 = n_r1;
        push0(8'h4F, 1'b0); push0(8'h4B, 1'b0); push0(8'h0D, 1'b1);
        wait_done("msg1_done", 500);
        e = {10'h14F, 10'h14B, 10'h10D};
        chk_log("msg1", base, e);
        check("msg1_r0", n_r0 - b_r0, 3);
        check("msg1_r1", n_r1 - b_r1, 0);
        check("msg1_grant_end", grant, 2'b00);

        // lone req1 byte, one-cycle latency; pointer ends on req1
        lat_req1("lat1", 8'hC3);

        // tie, round 1 then round 2: req0 wins both
        base = log_q.size();
        @(posedge clk);
        #1 push0(8'h11, 1'b0); push0(8'h12, 1'b1); push1(8'h21, 1'b0); push1(8'h22, 1'b1);
        wait_done("tie1_done", 500);
        e = {10'h111, 10'h112, 10'h221, 10'h222};
        chk_log("tie1", base, e);
        base = log_q.size();
        @(posedge clk);
        #1 push0(8'h31, 1'b0); push0(8'h32, 1'b1); push1(8'h41, 1'b0); push1(8'h42, 1'b1);
        wait_done("tie2_done", 500);
        e = {10'h131, 10'h132, 10'h241, 10'h242};
        chk_log("tie2", base, e);

        // req0 drops valid mid-message while req1 waits
        base = log_q.size(); b_r0 = n_r0; b_r1 = n_r1;
        @(posedge clk);
        #1 push0(8'h51, 1'b0); push0(8'h52, 1'b1); push1(8'h61, 1'b1);
        cyc = 0;
        while (n_r0 == b_r0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        hold0 = 1'b1;
        repeat (60) @(negedge clk);
        check("hold_grant", grant, 2'b01);
        check("hold_busy", busy, 1);
        check("hold_r1", n_r1 - b_r1, 0);
        hold0 = 1'b0;
        wait_done("hold_done", 500);
        e = {10'h151, 10'h152, 10'h261};
        chk_log("hold", base, e);
        check("hold_r1_end", n_r1 - b_r1, 1);

        // watchdog expiry with txd_flag withheld
        flag_en = 1'b0;
        b_to = n_to;
        push0(8'h71, 1'b1);
        wait_en("to_load");
        @(posedge clk);
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (timeout_err) break;
        end
        check("to_cycles", cyc, TO_CYC);
        check("to_grant", grant, 2'b00);
        check("to_busy", busy, 0);
        @(negedge clk);
        check("to_width", timeout_err, 0);
        check("to_count", n_to - b_to, 1);

        // txd_flag in the expiry cycle wins
        b_to = n_to;
        push0(8'h72, 1'b1);
        wait_en("same_load");
        @(posedge clk);
        repeat (TO_CYC - 1) @(posedge clk);
        #1 man_flag = 1'b1;
        @(posedge clk);
        #1 man_flag = 1'b0;
        @(negedge clk);
        check("same_busy", busy, 0);
        check("same_grant", grant, 2'b00);
        repeat (3) @(negedge clk);
        check("same_no_to", n_to - b_to, 0);

        // reset during WAIT
        push0(8'hA1, 1'b0); push0(8'hA2, 1'b1);
        wait_en("rstw_load");
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_grant", grant, 2'b00);
        check("rstw_busy", busy, 0);
        check("rstw_txd_en", txd_en, 0);
        check("rstw_txd_data", txd_data, 8'h00);
        check("rstw_ready", {req1_ready, req0_ready}, 2'b00);
        check("rstw_timeout", timeout_err, 0);
        b_en = n_en; b_r0 = n_r0; b_to = n_to;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        man_flag = 1'b1;
        @(negedge clk);
        man_flag = 1'b0;
        repeat (3) @(negedge clk);
        check("rstw_flag_ign", busy, 0);
        check("rstw_quiet", (n_en - b_en) + (n_r0 - b_r0) + (n_to - b_to), 0);
        flag_en = 1'b1;
        lat_req1("lat2", 8'hC7);
        check("rstw_no_r0", n_r0 - b_r0, 0);

        check("ready_ownership", n_bad, 0);
        check("grant_legal", n_gill, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
